matrix_vector_mac_seq: RTL and testbench

//  Time-multiplexed matrix*vector engine: one multiplier and one accumulator compute y = M*v serially.

---
 rtl/matrix_vector_mac_seq_if.sv | 20 ++
 rtl/matrix_vector_mac_seq.sv | 95 +++++++++
 tb/tb_matrix_vector_mac_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/matrix_vector_mac_seq_if.sv
// matrix_vector_mac_seq_if: job handshake and operand/result bus between host and serial matrix*vector engine
interface matrix_vector_mac_seq_if #(
  parameter int MATRIX_WIDTH  = 5,
  parameter int MATRIX_HEIGHT = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = 19
);
  logic                                          i_start;
  logic                                          i_abort;
  logic [MATRIX_WIDTH*MATRIX_HEIGHT*DATA_WIDTH-1:0] i_matrix;
  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]            i_vector;
  logic [MATRIX_HEIGHT*ACC_WIDTH-1:0]            o_result;
  logic                                          o_busy;
  logic                                          o_done;
  logic                                          o_overflow;
  modport master (output i_start, i_abort, i_matrix, i_vector,
                  input  o_result, o_busy, o_done, o_overflow);
  modport slave  (input  i_start, i_abort, i_matrix, i_vector,
                  output o_result, o_busy, o_done, o_overflow);
endinterface

// File: rtl/matrix_vector_mac_seq.sv
// matrix_vector_mac_seq: one-multiplier serial y = M*v engine; MVM_SAT_EN selects saturating accumulation with sticky overflow
module matrix_vector_mac_seq #(
  parameter int MATRIX_WIDTH  = 5,
  parameter int MATRIX_HEIGHT = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int ACC_WIDTH     = 19
) (
  input  logic                     clk,
  input  logic                     i_rst_n,
  matrix_vector_mac_seq_if.slave   bus
);
  localparam int RW = MATRIX_HEIGHT > 1 ? $clog2(MATRIX_HEIGHT) : 1;
  localparam int CW = MATRIX_WIDTH > 1 ? $clog2(MATRIX_WIDTH) : 1;
  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [RW-1:0] R_LAST = RW'(MATRIX_HEIGHT - 1);
  localparam logic [CW-1:0] C_LAST = CW'(MATRIX_WIDTH - 1);
  localparam logic [RW-1:0] R_ONE  = RW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;
  logic [MATRIX_WIDTH*MATRIX_HEIGHT*DATA_WIDTH-1:0] m_q;
  logic [MATRIX_WIDTH*DATA_WIDTH-1:0]               v_q;
  logic [MATRIX_HEIGHT*ACC_WIDTH-1:0]               result;
  logic [RW-1:0]         r;
  logic [CW-1:0]         c;
  logic [ACC_WIDTH-1:0]  acc, acc_next;
  logic [DATA_WIDTH-1:0] m_el, v_el;
  logic [PW-1:0]         prod;
  logic                  accept, step, last;
  assign accept = state == IDLE && bus.i_start && !bus.i_abort;
  assign step   = state == RUN && !bus.i_abort;
  assign last   = r == R_LAST && c == C_LAST;
  assign m_el   = m_q[(int'(r) * MATRIX_WIDTH + int'(c)) * DATA_WIDTH +: DATA_WIDTH];
  assign v_el   = v_q[int'(c) * DATA_WIDTH +: DATA_WIDTH];
  assign prod   = m_el * v_el;
  // state register
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_next;
  // sequencing: abort beats start in IDLE and cancels RUN; DONE always lasts one cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? RUN : IDLE;
      RUN:     state_next = bus.i_abort ? IDLE : last ? DONE : RUN;
      default: state_next = IDLE;
    endcase
  end
`ifdef MVM_SAT_EN
  localparam int SW = ACC_WIDTH + 1;
  logic [ACC_WIDTH:0] sum;
  logic               ovf;
  assign sum      = SW'(acc) + SW'(prod);
  assign acc_next = sum[ACC_WIDTH] ? '1 : sum[ACC_WIDTH-1:0];
  // overflow is sticky for the whole job and cleared only when a new job is accepted
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) ovf <= 1'b0;
    else if (accept) ovf <= 1'b0;
    else if (step) ovf <= ovf | sum[ACC_WIDTH];
  assign bus.o_overflow = ovf;
`else
  assign acc_next       = acc + ACC_WIDTH'(prod);
  assign bus.o_overflow = 1'b0;
`endif
  // operand snapshot, element walk and row write-back
  always_ff @(posedge clk or negedge i_rst_n)
    if (!i_rst_n) begin
      m_q    <= '0;
      v_q    <= '0;
      result <= '0;
      acc    <= '0;
      r      <= '0;
      c      <= '0;
    end else if (accept) begin
      m_q    <= bus.i_matrix;
      v_q    <= bus.i_vector;
      result <= '0;
      acc    <= '0;
      r      <= '0;
      c      <= '0;
    end else if (step) begin
      if (c == C_LAST) begin
        result[int'(r) * ACC_WIDTH +: ACC_WIDTH] <= acc_next;
        acc <= '0;
        c   <= '0;
        r   <= r == R_LAST ? '0 : r + R_ONE;
      end else begin
        acc <= acc_next;
        c   <= c + C_ONE;
      end
    end
  assign bus.o_result = result;
  assign bus.o_busy   = state == RUN;
  assign bus.o_done   = state == DONE;
endmodule

// File: tb/tb_matrix_vector_mac_seq.sv
// tb_matrix_vector_mac_seq: directed table-driven check of the serial matrix*vector engine (19- and 16-bit accumulators)
module tb_matrix_vector_mac_seq;
  localparam int W = 5, H = 5, DW = 8, AW = 19;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [W*H*DW-1:0] matrix = '0;
  logic [W*DW-1:0]   vector = '0;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  matrix_vector_mac_seq_if #(.ACC_WIDTH(19)) bus ();
  matrix_vector_mac_seq_if #(.ACC_WIDTH(16)) bus16 ();
  assign bus.i_start   = start;
  assign bus.i_abort   = abort;
  assign bus.i_matrix  = matrix;
  assign bus.i_vector  = vector;
  assign bus16.i_start  = start;
  assign bus16.i_abort  = abort;
  assign bus16.i_matrix = matrix;
  assign bus16.i_vector = vector;
  matrix_vector_mac_seq #(.ACC_WIDTH(19)) dut (.clk(clk), .i_rst_n(rst_n), .bus(bus));
  matrix_vector_mac_seq #(.ACC_WIDTH(16)) dut16 (.clk(clk), .i_rst_n(rst_n), .bus(bus16));
  typedef struct {
    string          name;
    logic [W*H*DW-1:0] m;
    logic [W*DW-1:0]   v;
    logic [H*AW-1:0]   y;
  } vec_t;
  vec_t tbl[5];
  function automatic logic [H*AW-1:0] pk(input int a0, a1, a2, a3, a4);
    pk = {19'(a4), 19'(a3), 19'(a2), 19'(a1), 19'(a0)};
  endfunction
  function automatic logic [W*DW-1:0] vec(input int a0, a1, a2, a3, a4);
    vec = {8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction
  function automatic logic [W*H*DW-1:0] mat(input int kind);
    mat = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        mat[(r*W+c)*DW +: DW] = kind == 0 ? 8'(r == c) : kind == 1 ? 8'd255 :
                                kind == 2 ? 8'(r + 1)  : kind == 3 ? 8'd1 : 8'(r*W + c);
  endfunction
  function automatic logic [W*H*DW-1:0] rnd();
    logic [223:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    rnd = t[W*H*DW-1:0];
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic run_job(input logic [W*H*DW-1:0] m, input logic [W*DW-1:0] v, output int lat, output int busy_n);
    logic [W*H*DW-1:0] t;
    @(negedge clk);
    matrix = m;
    vector = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    matrix = rnd();
    t      = rnd();
    vector = t[W*DW-1:0];
    lat    = 0;
    busy_n = 0;
    while (!bus.o_done && lat < 100) begin
      busy_n += int'(bus.o_busy);
      @(negedge clk);
      lat++;
    end
  endtask
  initial begin
    int lat, busy_n, t1, t2, n_done;
    logic [15:0] e16;
    logic        eo16;
`ifdef MVM_SAT_EN
    e16  = 16'd65535;
    eo16 = 1'b1;
`else
    e16  = 16'd62981;
    eo16 = 1'b0;
`endif
    tbl[0] = '{"identity", mat(0), vec(1, 2, 3, 4, 5),      pk(1, 2, 3, 4, 5)};
    tbl[1] = '{"all255",   mat(1), vec(255, 255, 255, 255, 255), pk(325125, 325125, 325125, 325125, 325125)};
    tbl[2] = '{"rowconst", mat(2), vec(1, 2, 3, 4, 5),      pk(15, 30, 45, 60, 75)};
    tbl[3] = '{"ones",     mat(3), vec(10, 20, 30, 40, 50), pk(150, 150, 150, 150, 150)};
    tbl[4] = '{"ramp",     mat(4), vec(1, 0, 0, 0, 2),      pk(8, 23, 38, 53, 68)};
    repeat (2) @(negedge clk);
    chk("reset busy", 128'(bus.o_busy), 0);
    chk("reset done", 128'(bus.o_done), 0);
    chk("reset result", 128'(bus.o_result), 0);
    chk("reset overflow", 128'(bus.o_overflow), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_job(tbl[i].m, tbl[i].v, lat, busy_n);
      chk($sformatf("%s latency", tbl[i].name), 128'(lat), 25);
      chk($sformatf("%s busy cycles", tbl[i].name), 128'(busy_n), 25);
      @(negedge clk);
      chk($sformatf("%s done pulse width", tbl[i].name), 128'(bus.o_done), 0);
      chk($sformatf("%s result", tbl[i].name), 128'(bus.o_result), 128'(tbl[i].y));
      chk($sformatf("%s overflow", tbl[i].name), 128'(bus.o_overflow), 0);
      if (i == 1) begin
        chk("acc16 result", 128'(bus16.o_result), 128'({5{e16}}));
        chk("acc16 overflow", 128'(bus16.o_overflow), 128'(eo16));
      end
    end
    @(negedge clk);
    matrix = mat(3);
    vector = vec(10, 20, 30, 40, 50);
    start  = 1'b1;
    n_done = 0;
    while (!bus.o_done && n_done < 100) begin @(negedge clk); n_done++; end
    t1 = cyc;
    @(negedge clk);
    n_done = 0;
    while (!bus.o_done && n_done < 100) begin @(negedge clk); n_done++; end
    t2 = cyc;
    start = 1'b0;
    chk("held start interval", 128'(t2 - t1), 27);
    chk("held start result", 128'(bus.o_result), 128'(tbl[3].y));
    @(negedge clk);
    chk("held start release idle", 128'(bus.o_busy), 0);
    @(negedge clk);
    chk("held start no queue", 128'(bus.o_busy), 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", 128'(bus.o_busy), 0);
    chk("abort done", 128'(bus.o_done), 0);
    n_done = 0;
    repeat (30) begin @(negedge clk); n_done += int'(bus.o_done); end
    chk("abort no done", 128'(n_done), 0);
    chk("abort partial result", 128'(bus.o_result), 128'(pk(150, 0, 0, 0, 0)));
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("start+abort idle", 128'(bus.o_busy), 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("start+abort dropped", 128'(bus.o_busy), 0);
    chk("start+abort result kept", 128'(bus.o_result), 128'(pk(150, 0, 0, 0, 0)));
    matrix = mat(3);
    vector = vec(10, 20, 30, 40, 50);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", 128'(bus.o_busy), 0);
    chk("async reset done", 128'(bus.o_done), 0);
    chk("async reset result", 128'(bus.o_result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(tbl[2].m, tbl[2].v, lat, busy_n);
    chk("post-reset latency", 128'(lat), 25);
    @(negedge clk);
    chk("post-reset result", 128'(bus.o_result), 128'(tbl[2].y));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
